// File: rtl/div_unit.sv
// Signed 32-bit restoring divider: 32 iterations plus one sign-fix cycle.
// Optional DIV_ZERO_EXC_EN: b=0 raises div_zero and skips the iteration.
module div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t      state, next_state;
    logic [31:0] dividend_q;   // dividend shifts out the top, quotient shifts in the bottom
    logic [31:0] divisor_q;
    logic [31:0] rem_q;
    logic        sign_a_q, sign_b_q;
    logic [4:0]  count_q;
    logic [32:0] rem_shift, diff;
    logic        q_bit;
    logic        zero_div;

`ifdef DIV_ZERO_EXC_EN
    assign zero_div = (b == 32'd0);
`else
    assign zero_div = 1'b0;
`endif

    // One restoring step: with the invariant rem < divisor, diff[32] is the borrow.
    assign rem_shift = {rem_q, dividend_q[31]};
    assign diff      = rem_shift - {1'b0, divisor_q};
    assign q_bit     = ~diff[32];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = zero_div ? DONE : CALC;
            CALC: if (count_q == 5'd31) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi         <= 32'd0;
            lo         <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            count_q    <= 5'd0;
            rem_q      <= 32'd0;
            dividend_q <= 32'd0;
            divisor_q  <= 32'd0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
        end else begin
            busy <= (next_state != IDLE);
            done <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        dividend_q <= a[31] ? -a : a;
                        divisor_q  <= b[31] ? -b : b;
                        sign_a_q   <= a[31];
                        sign_b_q   <= b[31];
                        count_q    <= 5'd0;
                        rem_q      <= 32'd0;
                    end
                end
                CALC: begin
                    dividend_q <= {dividend_q[30:0], q_bit};
                    rem_q      <= q_bit ? diff[31:0] : rem_shift[31:0];
                    count_q    <= count_q + 5'd1;
                end
                FIX: begin
                    lo <= (sign_a_q ^ sign_b_q) ? -dividend_q : dividend_q;
                    hi <= sign_a_q ? -rem_q : rem_q;
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_ZERO_EXC_EN
    always_ff @(posedge clk) begin
        if (reset)                      div_zero <= 1'b0;
        else if (state == IDLE && start) div_zero <= zero_div;
    end
`else
    assign div_zero = 1'b0;
`endif

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 Port clk SHALL be: input, 1 bit, rising-edge clock for all state.
REQ-003 Port reset SHALL be: input, 1 bit, synchronous active-high reset.
REQ-004 Port start SHALL be: input, 1 bit, request a new division, sampled only in IDLE.
REQ-005 Port a SHALL be: input, 32 bits, signed dividend (register A), sampled at the accepted start edge.
REQ-006 Port b SHALL be: input, 32 bits, signed divisor (register B), sampled at the accepted start edge.
REQ-007 Port hi SHALL be: output, 32 bits, registered remainder, feeding the HI-source mux data_1 input.
REQ-008 Port lo SHALL be: output, 32 bits, registered quotient, feeding the LO-source mux data_1 input.
REQ-009 Port busy SHALL be: output, 1 bit, high whenever state is not IDLE.
REQ-010 Port done SHALL be: output, 1 bit, single-cycle pulse when hi/lo hold a new result.
REQ-011 Port div_zero SHALL be: output, 1 bit, divide-by-zero flag for the control unit.

Function
REQ-012 States SHALL be IDLE, CALC, FIX and DONE.
REQ-013 IDLE: start=1 at edge k SHALL latch |a|, |b| and both sign bits, clear the 5-bit iteration counter and the partial remainder, and enter CALC.
REQ-014 CALC SHALL perform one unsigned restoring-division step per cycle, MSB first, for exactly 32 cycles (edges k+1..k+32), then enter FIX.
REQ-015 FIX at edge k+33 SHALL write lo = quotient, negated if sign(a) XOR sign(b), and hi = remainder, negated if sign(a); it SHALL then enter DONE.
REQ-016 DONE SHALL hold done=1 for exactly one cycle and return to IDLE; hi and lo SHALL hold their values until the next result or reset.
REQ-017 The quotient SHALL truncate toward zero and the remainder SHALL take the sign of the dividend.
REQ-018 Magnitudes SHALL be 32-bit unsigned, so a=0x80000000, b=0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 with no flag.
REQ-019 start while busy=1 SHALL be ignored; a and b are not re-sampled.
REQ-020 start and reset asserted at the same edge: reset SHALL win.
REQ-021 div_zero SHALL stay set until the next accepted start or reset.
REQ-022 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-023 reset=1 at any edge, including mid-CALC or mid-FIX, SHALL force state IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0 and counter=0; any operation in progress SHALL be abandoned without a done pulse.

Configuration
REQ-024 Macro DIV_ZERO_EXC_EN defined: an accepted start with b=0 SHALL skip CALC/FIX, go directly to DONE at edge k+1, set div_zero=1, pulse done, and leave hi/lo unchanged.
REQ-025 Macro DIV_ZERO_EXC_EN undefined: div_zero SHALL be constant 0, and b=0 SHALL run the full 33-cycle sequence with quotient magnitude 0xFFFFFFFF and remainder = a, signs fixed per REQ-015 (a=5 gives lo=0xFFFFFFFF, hi=5; a=-5 gives lo=0x00000001, hi=0xFFFFFFFB).

Verification
REQ-026 a=7, b=2, start at edge k -> busy=1 from k, hi/lo update at k+33 with lo=3, hi=1, done=1 for one cycle, then busy=0.
REQ-027 a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; a=7, b=-2 -> lo=0xFFFFFFFD, hi=1.
REQ-028 a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-029 With DIV_ZERO_EXC_EN, after a 7/2 result, a=9, b=0 -> at k+1 div_zero=1, done=1, hi=1, lo=3 retained; without the macro -> lo=0xFFFFFFFF, hi=9 at k+33.
REQ-030 Reset mid-operation (a=100, b=3, reset at the 10th CALC cycle) -> next cycle busy=0, hi=lo=0, no done pulse; a subsequent 100/3 -> lo=33, hi=1.
REQ-031 Ignored start: start pulsed again at k+5 with a=50, b=5 -> result is still 7/2 (lo=3, hi=1) and only one done pulse occurs.
